aes_resp_collector: RTL and testbench
=====================================

// Module: aes_resp_collector
// PURPOSE
//  Result-side end of the aes_build request interface. Each job launched into the AES core is
//  logged with its func and tag. Each call_complete pulse captures ciphertext/plaintext, pairs it
//  in order with the oldest logged job, and buffers the result for a downstream consumer (valid/ready).
//  Issue-side credit (issue_rdy) guarantees a completion is never dropped.
// PARAMETERS
//  DEPTH   4    max jobs in flight + buffered results combined (power of 2, >=2)
//  TAG_W   4    width of the job tag carried from issue to response
// PORTS
//  eph1            in   1      clock
//  reset           in   1      synchronous, active-high reset
//  issue_v         in   1      job launched into core this cycle
//  issue_rdy       out  1      collector can accept a job log entry
//  issue_func      in   2      aes_func_e of launched job
//  issue_tag       in   TAG_W  caller tag of launched job
//  call_complete   in   1      core result valid this cycle (single-cycle pulse)
//  ciphertext      in   128    core ciphertext output
//  plaintext       in   128    core plaintext output
//  resp_v          out  1      response valid
//  resp_rdy        in   1      consumer accepts response
//  resp_data       out  128    selected result word
//  resp_func       out  2      func of the job
//  resp_tag        out  TAG_W  tag of the job
//  outstanding     out  $clog2(DEPTH)+1  jobs issued but not completed
//  err_unexpected  out  1      sticky: call_complete seen with no outstanding job
//  err_bad_func    out  1      sticky: issue_v with func 2'h0
// BEHAVIOUR
//  - Reset: all FIFOs empty; issue_rdy=1, resp_v=0, resp_data/func/tag=0, outstanding=0, errors=0.
//    Reset mid-operation discards all pending and buffered entries; a call_complete arriving in
//    the reset cycle is ignored.
//  - func: 2'h1 ENC -> resp_data=ciphertext; 2'h2 DEC -> plaintext; 2'h3 ENC_DEC -> plaintext.
//    2'h0 is illegal: not logged, err_bad_func set, credits unchanged.
//  - Credit: issue_rdy = (pend_cnt + resp_cnt) < DEPTH. Accept = issue_v & issue_rdy & legal func.
//    issue_v while !issue_rdy is a caller error: dropped, no flag.
//  - Completion: call_complete & pend not empty pops the pend FIFO head and pushes
//    {sel data, func, tag} to the resp FIFO. resp_v rises the cycle after call_complete (1-cycle latency).
//  - call_complete with pend empty: result dropped, err_unexpected set. It stays set until reset.
//  - Same-cycle accept + completion: both take effect. A job accepted in cycle N is never paired with a
//    completion in cycle N.
//  - Same-cycle push + pop on resp: both take effect. Count unchanged.
//  - Responses leave in completion order. resp_* are held stable while resp_v & !resp_rdy.
//  - outstanding = pend_cnt. It is exact in every cycle and saturates at DEPTH.
// CONFIGURATION
//  AES_COLLECT_CHECK_EN defined: extra ports exp_v/exp_data[127:0] (in), mismatch (out, 1-cycle pulse)
//    and mismatch_cnt[15:0] (out, saturating). exp_data is logged alongside each accepted job.
//    On the resp pop handshake, mismatch pulses if resp_data != logged exp_data and exp_v was 1 at issue.
//  Undefined: no check ports, no exp storage. Behaviour is otherwise identical.
// STRUCTURE
//  Package aes_collect_pkg: aes_func_e (NONE=0, ENC=1, DEC=2, ENC_DEC=3),
//    aes_pend_t {func, tag[, exp_v, exp_data]}, aes_resp_t {data, func, tag}.
//  Sub-module aes_sync_fifo #(type T, DEPTH): registered-output sync FIFO on eph1/reset,
//    with push, pop, full, empty and count. Instantiated twice (pend, resp).
//  Top level: credit logic, data select, error flags, optional checker.
// TESTING
//  1 Issue ENC tag 5, then call_complete with ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a
//    -> next cycle resp_v=1, resp_data=69c4..c55a, resp_tag=5, outstanding 1->0.
//  2 Issue DEC tag 2 and ENC_DEC tag 3 -> resp_data is plaintext for both, in order (tag 2 then 3).
//  3 Hold resp_rdy=0 and issue DEPTH jobs -> issue_rdy=0 after the 4th. Complete all 4 -> no loss.
//    Then set resp_rdy=1 -> tags drain in issue order. issue_rdy returns after the first pop.
//  4 call_complete with nothing issued -> err_unexpected=1 and sticky, resp_v stays 0.
//    issue_func=0 -> err_bad_func=1, outstanding unchanged.
//  5 Issue and complete in the same cycle, plus resp push/pop in the same cycle -> counts stay
//    consistent, no duplicated or dropped response. Assert reset mid-stream -> all empty next cycle.
//  6 (CHECK_EN) exp_data=69c4..c55a vs resp 69c4..c55b -> mismatch pulses once at the pop,
//    mismatch_cnt=1.

Source files
------------

// File: rtl/aes_collect_pkg.sv
// Shared types for the AES response collector: job function codes and FIFO payloads.
// Check fields are present only when AES_COLLECT_CHECK_EN is defined.
package aes_collect_pkg;

    localparam int unsigned AES_TAG_W  = 4;
    localparam int unsigned AES_DATA_W = 128;

    typedef enum logic [1:0] {
        AES_NONE    = 2'h0,
        AES_ENC     = 2'h1,
        AES_DEC     = 2'h2,
        AES_ENC_DEC = 2'h3
    } aes_func_e;

    typedef struct packed {
        aes_func_e              func;
        logic [AES_TAG_W-1:0]   tag;
`ifdef AES_COLLECT_CHECK_EN
        logic                   exp_v;
        logic [AES_DATA_W-1:0]  exp_data;
`endif
    } aes_pend_t;

    typedef struct packed {
        logic [AES_DATA_W-1:0]  data;
        aes_func_e              func;
        logic [AES_TAG_W-1:0]   tag;
`ifdef AES_COLLECT_CHECK_EN
        logic                   miss;   // result differed from the expected value logged at issue
`endif
    } aes_resp_t;

    // Only a pure encrypt returns ciphertext; decrypt and round-trip return plaintext.
    function automatic logic [AES_DATA_W-1:0] aes_sel_data(aes_func_e func,
                                                           logic [AES_DATA_W-1:0] ct,
                                                           logic [AES_DATA_W-1:0] pt);
        return (func == AES_ENC) ? ct : pt;
    endfunction

endpackage

// File: rtl/aes_sync_fifo.sv
// Synchronous FIFO with registered head: entries shift toward slot 0 on pop, so dout is a flop.
module aes_sync_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   eph1,
    input  logic                   reset,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic             push_eff;
    logic             pop_eff;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] wr_idx;

    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);
    assign dout     = mem_q[0];

    // Next storage image: shift on pop, then write at the first free slot after the shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_idx = pop_eff ? (count - CNT_W'(1)) : count;
        if (pop_eff) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
        end
        if (push_eff) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    mem_d[i] = din;
                end
            end
        end
        cnt_d = count + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end

    always_ff @(posedge eph1) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            count <= cnt_d;
            empty <= (cnt_d == '0);
            full  <= (cnt_d == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/aes_resp_collector.sv
// Pairs AES core completions with logged jobs in order and buffers results for a valid/ready consumer.
// Define AES_COLLECT_CHECK_EN to add expected-data checking (exp_v/exp_data, mismatch, mismatch_cnt).
module aes_resp_collector
    import aes_collect_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = AES_TAG_W
) (
    input  logic                   eph1,
    input  logic                   reset,
    input  logic                   issue_v,
    output logic                   issue_rdy,
    input  logic [1:0]             issue_func,
    input  logic [TAG_W-1:0]       issue_tag,
    input  logic                   call_complete,
    input  logic [127:0]           ciphertext,
    input  logic [127:0]           plaintext,
    output logic                   resp_v,
    input  logic                   resp_rdy,
    output logic [127:0]           resp_data,
    output logic [1:0]             resp_func,
    output logic [TAG_W-1:0]       resp_tag,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_unexpected,
`ifdef AES_COLLECT_CHECK_EN
    input  logic                   exp_v,
    input  logic [127:0]           exp_data,
    output logic                   mismatch,
    output logic [15:0]            mismatch_cnt,
`endif
    output logic                   err_bad_func
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    aes_pend_t        pend_in;
    aes_pend_t        pend_head;
    aes_resp_t        resp_in;
    aes_resp_t        resp_head;
    logic             pend_full;
    logic             pend_empty;
    logic             resp_full;
    logic             resp_empty;
    logic [CNT_W-1:0] pend_cnt;
    logic [CNT_W-1:0] resp_cnt;
    logic             func_legal;
    logic             accept;
    logic             complete;
    logic             resp_pop;
    logic [127:0]     sel_data;
    logic [SUM_W-1:0] total_nxt;

    assign func_legal = (issue_func != AES_NONE);
    assign accept     = issue_v & issue_rdy & func_legal & ~pend_full;
    // A job accepted this cycle is not yet visible in pend, so it never pairs with this cycle's completion.
    assign complete   = call_complete & ~pend_empty & (~resp_full | resp_pop);
    assign resp_pop   = ~resp_empty & resp_rdy;
    assign sel_data   = aes_sel_data(pend_head.func, ciphertext, plaintext);
    assign total_nxt  = SUM_W'(pend_cnt) + SUM_W'(resp_cnt) + SUM_W'(accept) - SUM_W'(resp_pop);

    always_comb begin
        pend_in          = '0;
        pend_in.func     = aes_func_e'(issue_func);
        pend_in.tag      = AES_TAG_W'(issue_tag);
`ifdef AES_COLLECT_CHECK_EN
        pend_in.exp_v    = exp_v;
        pend_in.exp_data = exp_data;
`endif
    end

    always_comb begin
        resp_in      = '0;
        resp_in.data = sel_data;
        resp_in.func = pend_head.func;
        resp_in.tag  = pend_head.tag;
`ifdef AES_COLLECT_CHECK_EN
        resp_in.miss = pend_head.exp_v & (sel_data != pend_head.exp_data);
`endif
    end

    aes_sync_fifo #(.T(aes_pend_t), .DEPTH(DEPTH)) u_pend_fifo (
        .eph1  (eph1),
        .reset (reset),
        .push  (accept),
        .din   (pend_in),
        .pop   (complete),
        .dout  (pend_head),
        .full  (pend_full),
        .empty (pend_empty),
        .count (pend_cnt)
    );

    aes_sync_fifo #(.T(aes_resp_t), .DEPTH(DEPTH)) u_resp_fifo (
        .eph1  (eph1),
        .reset (reset),
        .push  (complete),
        .din   (resp_in),
        .pop   (resp_pop),
        .dout  (resp_head),
        .full  (resp_full),
        .empty (resp_empty),
        .count (resp_cnt)
    );

    assign resp_v      = ~resp_empty;
    assign resp_data   = resp_head.data;
    assign resp_func   = resp_head.func;
    assign resp_tag    = TAG_W'(resp_head.tag);
    assign outstanding = pend_cnt;

    // Credit and sticky error flags.
    always_ff @(posedge eph1) begin
        if (reset) begin
            issue_rdy      <= 1'b1;
            err_unexpected <= 1'b0;
            err_bad_func   <= 1'b0;
        end else begin
            issue_rdy <= (total_nxt < SUM_W'(DEPTH));
            if (call_complete && pend_empty) begin
                err_unexpected <= 1'b1;
            end
            if (issue_v && !func_legal) begin
                err_bad_func <= 1'b1;
            end
        end
    end

`ifdef AES_COLLECT_CHECK_EN
    always_ff @(posedge eph1) begin
        if (reset) begin
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            mismatch <= resp_pop & resp_head.miss;
            if (resp_pop && resp_head.miss && (mismatch_cnt != 16'hffff)) begin
                mismatch_cnt <= mismatch_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_resp_collector.sv
// Randomized bench for aes_resp_collector against a queue-based reference model.
// Check ports are exercised when AES_COLLECT_CHECK_EN is defined.
module tb_aes_resp_collector;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam logic [127:0] KAT_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         eph1 = 1'b0;
    logic         reset;
    logic         issue_v;
    logic         issue_rdy;
    logic [1:0]   issue_func;
    logic [3:0]   issue_tag;
    logic         call_complete;
    logic [127:0] ciphertext;
    logic [127:0] plaintext;
    logic         resp_v;
    logic         resp_rdy;
    logic [127:0] resp_data;
    logic [1:0]   resp_func;
    logic [3:0]   resp_tag;
    logic [2:0]   outstanding;
    logic         err_unexpected;
    logic         err_bad_func;
    logic         exp_v;
    logic [127:0] exp_data;
`ifdef AES_COLLECT_CHECK_EN
    logic         mismatch;
    logic [15:0]  mismatch_cnt;
`endif

    always #5 eph1 = ~eph1;

    aes_resp_collector #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .eph1           (eph1),
        .reset          (reset),
        .issue_v        (issue_v),
        .issue_rdy      (issue_rdy),
        .issue_func     (issue_func),
        .issue_tag      (issue_tag),
        .call_complete  (call_complete),
        .ciphertext     (ciphertext),
        .plaintext      (plaintext),
        .resp_v         (resp_v),
        .resp_rdy       (resp_rdy),
        .resp_data      (resp_data),
        .resp_func      (resp_func),
        .resp_tag       (resp_tag),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected),
`ifdef AES_COLLECT_CHECK_EN
        .exp_v          (exp_v),
        .exp_data       (exp_data),
        .mismatch       (mismatch),
        .mismatch_cnt   (mismatch_cnt),
`endif
        .err_bad_func   (err_bad_func)
    );

    typedef struct {
        logic [127:0] data;
        logic [1:0]   func;
        logic [3:0]   tag;
        logic         ev;
        logic [127:0] ed;
    } job_t;

    job_t pend_q[$];
    job_t resp_q[$];
    bit   m_unexp;
    bit   m_bad;
    bit   m_mism;
    int   m_mcnt;
    int   n_cmp;
    int   n_err;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("issue_rdy", 128'(issue_rdy), 128'((pend_q.size() + resp_q.size()) < DEPTH));
        check("outstanding", 128'(outstanding), 128'(pend_q.size()));
        check("resp_v", 128'(resp_v), 128'(resp_q.size() != 0));
        if (resp_q.size() != 0) begin
            check("resp_data", resp_data, resp_q[0].data);
            check("resp_func", 128'(resp_func), 128'(resp_q[0].func));
            check("resp_tag", 128'(resp_tag), 128'(resp_q[0].tag));
        end
        check("err_unexpected", 128'(err_unexpected), 128'(m_unexp));
        check("err_bad_func", 128'(err_bad_func), 128'(m_bad));
`ifdef AES_COLLECT_CHECK_EN
        check("mismatch", 128'(mismatch), 128'(m_mism));
        check("mismatch_cnt", 128'(mismatch_cnt), 128'(m_mcnt));
`endif
    endtask

    // Compare the current outputs, advance the model by the rules for this cycle's inputs, clock once.
    task automatic step();
        job_t j;
        bit   pop;
        bit   rdy;
        check_outputs();
        if (reset) begin
            pend_q.delete();
            resp_q.delete();
            m_unexp = 0;
            m_bad   = 0;
            m_mism  = 0;
            m_mcnt  = 0;
        end else begin
            pop    = (resp_q.size() != 0) && resp_rdy;
            rdy    = (pend_q.size() + resp_q.size()) < DEPTH;
            m_mism = 0;
            if (pop) begin
                j = resp_q.pop_front();
                if (j.ev && (j.data != j.ed)) begin
                    m_mism = 1;
                    if (m_mcnt < 65535) m_mcnt++;
                end
            end
            if (issue_v && issue_func == 2'h0) m_bad = 1;
            if (call_complete) begin
                if (pend_q.size() != 0) begin
                    j      = pend_q.pop_front();
                    j.data = (j.func == 2'h1) ? ciphertext : plaintext;
                    resp_q.push_back(j);
                end else begin
                    m_unexp = 1;
                end
            end
            if (issue_v && rdy && issue_func != 2'h0) begin
                j      = '{data: '0, func: issue_func, tag: issue_tag, ev: exp_v, ed: exp_data};
                pend_q.push_back(j);
            end
        end
        @(posedge eph1);
        #1;
    endtask

    task automatic idle();
        reset         = 1'b0;
        issue_v       = 1'b0;
        issue_func    = 2'h0;
        issue_tag     = 4'h0;
        call_complete = 1'b0;
        ciphertext    = '0;
        plaintext     = '0;
        exp_v         = 1'b0;
        exp_data      = '0;
    endtask

    task automatic issue(input logic [1:0] f, input logic [3:0] t);
        idle();
        issue_v    = 1'b1;
        issue_func = f;
        issue_tag  = t;
        step();
    endtask

    task automatic complete(input logic [127:0] ct, input logic [127:0] pt);
        idle();
        call_complete = 1'b1;
        ciphertext    = ct;
        plaintext     = pt;
        step();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        idle();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        resp_rdy = 1'b0;
        idle();
        reset = 1'b1;
        @(posedge eph1);
        #1;
        do_reset();
        check("rst_issue_rdy", 128'(issue_rdy), 128'(1));
        check("rst_resp_data", resp_data, '0);
        check("rst_resp_tag", 128'(resp_tag), '0);

        // Known-answer encrypt with a 1-cycle response.
        issue(2'h1, 4'h5);
        check("t1_outstanding", 128'(outstanding), 128'(1));
        complete(KAT_CT, 128'h1);
        check("t1_resp_v", 128'(resp_v), 128'(1));
        check("t1_resp_data", resp_data, KAT_CT);
        check("t1_resp_tag", 128'(resp_tag), 128'(5));
        check("t1_outstanding0", 128'(outstanding), '0);
        resp_rdy = 1'b1;
        idle();
        step();

        // Decrypt and round-trip both return plaintext, in issue order.
        issue(2'h2, 4'h2);
        issue(2'h3, 4'h3);
        complete(128'hc1, 128'hd2);
        complete(128'hc3, 128'hd4);
        step();
        step();

        // Fill to DEPTH with the consumer stalled, then drain.
        resp_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) issue(2'h1, 4'(i + 8));
        check("t3_full_rdy", 128'(issue_rdy), '0);
        issue(2'h1, 4'hf);
        for (int i = 0; i < DEPTH; i++) complete(128'(i + 100), 128'(i + 200));
        check("t3_still_full", 128'(issue_rdy), '0);
        resp_rdy = 1'b1;
        step();
        check("t3_rdy_back", 128'(issue_rdy), 128'(1));
        for (int i = 0; i < DEPTH; i++) step();

        // Error flags.
        complete(128'hdead, 128'hbeef);
        check("t4_unexp", 128'(err_unexpected), 128'(1));
        check("t4_resp_v", 128'(resp_v), '0);
        issue(2'h0, 4'h7);
        check("t4_bad", 128'(err_bad_func), 128'(1));
        check("t4_outst", 128'(outstanding), '0);
        step();
        check("t4_sticky", 128'(err_unexpected), 128'(1));
        do_reset();

        // Simultaneous accept/complete and push/pop; then reset with a completion pending.
        issue(2'h1, 4'h1);
        complete(128'haa, 128'hbb);
        issue(2'h2, 4'h2);
        idle();
        issue_v = 1'b1; issue_func = 2'h3; issue_tag = 4'h3;
        call_complete = 1'b1; ciphertext = 128'hcc; plaintext = 128'hdd;
        step();
        check("t5_outst", 128'(outstanding), 128'(1));
        idle();
        reset = 1'b1; call_complete = 1'b1;
        step();
        idle();
        check("t5_rst_outst", 128'(outstanding), '0);
        check("t5_rst_resp_v", 128'(resp_v), '0);
        step();

`ifdef AES_COLLECT_CHECK_EN
        // Expected-value checker flags a one-bit ciphertext difference once.
        resp_rdy = 1'b0;
        idle();
        issue_v = 1'b1; issue_func = 2'h1; issue_tag = 4'h6;
        exp_v = 1'b1; exp_data = KAT_CT;
        step();
        complete(KAT_CT ^ 128'h1, '0);
        resp_rdy = 1'b1;
        step();
        check("t6_mismatch", 128'(mismatch), 128'(1));
        check("t6_mcnt", 128'(mismatch_cnt), 128'(1));
        step();
        check("t6_pulse", 128'(mismatch), '0);
        do_reset();
`endif

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            idle();
            reset         = ($urandom_range(0, 199) == 0);
            issue_v       = ($urandom_range(0, 2) != 0);
            issue_func    = ($urandom_range(0, 15) == 0) ? 2'h0 : 2'($urandom_range(1, 3));
            issue_tag     = 4'($urandom);
            call_complete = ($urandom_range(0, 2) == 0);
            ciphertext    = rnd128();
            plaintext     = rnd128();
            exp_v         = $urandom_range(0, 1) == 1;
            exp_data      = ($urandom_range(0, 1) == 1) ? ciphertext : plaintext;
            resp_rdy      = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
